// File: rtl/fpregfile_wb.sv
// FP write-back/commit stage: merges load and FPU results into one regfile write per cycle.
// Optional check bits are enabled by defining FPREGFILE_PARITY_EN.
package fpregfile_pkg;
    localparam int NFPREGADDRMSB = 4;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic [NFPREGADDRMSB:0] ph_addr;
        logic [31:0]            ph1_data;
        logic [31:0]            ph2_data;
        logic [6:0]             ph1_parity;
        logic [6:0]             ph2_parity;
        logic                   ph1_we;
        logic                   ph2_we;
    } fpregfile_commit_type;
endpackage

module fpregfile_wb
    import fpregfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  iu_clk_type                 gclk,
    input  logic                       rst,
    input  logic                       ld_valid,
    input  logic [NFPREGADDRMSB:0]     ld_addr,
    input  logic                       ld_dbl,
    input  logic [63:0]                ld_data,
    input  logic                       fpu_valid,
    output logic                       fpu_ready,
    input  logic [NFPREGADDRMSB:0]     fpu_addr,
    input  logic                       fpu_dbl,
    input  logic [63:0]                fpu_data,
    input  logic [NFPREGADDRMSB:0]     chk_addr,
    output logic                       chk_hit,
    output fpregfile_commit_type       rfc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int AW = NFPREGADDRMSB + 1;

    logic clk;
    assign clk = gclk.clk;

    logic [AW-1:0] q_addr [FIFO_DEPTH];
    logic          q_dbl  [FIFO_DEPTH];
    logic [63:0]   q_data [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_nxt;
    logic          ready_q;
    logic          push, pop, sel_valid;
    logic [AW-1:0] sel_addr;
    logic          sel_dbl;
    logic [63:0]   sel_data;

    function automatic logic addr_match(input logic [AW-1:0] a, input logic dbl,
                                        input logic [AW-1:0] probe);
        if (dbl) return a[AW-1:1] == probe[AW-1:1];
        return a == probe;
    endfunction

    // Double writes both halves; single data is replicated and the lsb picks the word.
    function automatic fpregfile_commit_type commit_fmt(input logic [AW-1:0] a, input logic dbl,
                                                        input logic [63:0] d);
        fpregfile_commit_type c;
        c = '0;
        c.ph_addr  = a;
        c.ph1_data = d[31:0];
        c.ph2_data = dbl ? d[63:32] : d[31:0];
        c.ph1_we   = dbl | ~a[0];
        c.ph2_we   = dbl | a[0];
`ifdef FPREGFILE_PARITY_EN
        c.ph1_parity = {^c.ph1_data[31:24], ^c.ph1_data[23:16], ^c.ph1_data[15:8], ^c.ph1_data[7:0], 3'b000};
        c.ph2_parity = {^c.ph2_data[31:24], ^c.ph2_data[23:16], ^c.ph2_data[15:8], ^c.ph2_data[7:0], 3'b000};
`endif
        return c;
    endfunction

    assign fpu_ready = ready_q;
    assign push      = fpu_valid & ready_q;
    assign pop       = ~ld_valid & (count != '0);
    assign sel_valid = ld_valid | pop;
    assign sel_addr  = ld_valid ? ld_addr : q_addr[rd_ptr];
    assign sel_dbl   = ld_valid ? ld_dbl  : q_dbl[rd_ptr];
    assign sel_data  = ld_valid ? ld_data : q_data[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (PW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            rfc     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count   <= count_nxt;
            // Ready depends on registered occupancy only, never on a same-cycle pop.
            ready_q <= (count_nxt != (PW+1)'(FIFO_DEPTH));
            rfc     <= sel_valid ? commit_fmt(sel_addr, sel_dbl, sel_data) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= fpu_addr;
            q_dbl[wr_ptr]  <= fpu_dbl;
            q_data[wr_ptr] <= fpu_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - rd_ptr)} < count) && addr_match(q_addr[i], q_dbl[i], chk_addr))
                chk_hit = 1'b1;
        end
        if ((rfc.ph1_we | rfc.ph2_we) && addr_match(rfc.ph_addr, rfc.ph1_we & rfc.ph2_we, chk_addr))
            chk_hit = 1'b1;
    end
endmodule

// File: tb/tb_fpregfile_wb.sv
// Bench for fpregfile_wb: directed steps plus a random phase, checked against a cycle model
// and an expected-commit queue.
module tb_fpregfile_wb;
    import fpregfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = NFPREGADDRMSB + 1;
    localparam int CW    = $bits(fpregfile_commit_type);

    iu_clk_type           gclk;
    logic                 rst;
    logic                 ld_valid, ld_dbl, fpu_valid, fpu_dbl;
    logic [AW-1:0]        ld_addr, fpu_addr, chk_addr;
    logic [63:0]          ld_data, fpu_data;
    logic                 fpu_ready, chk_hit;
    fpregfile_commit_type rfc;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] exp_q[$];
    logic [AW-1:0] mq_addr[$];
    logic          mq_dbl[$];
    logic [63:0]   mq_data[$];
    logic          ready_m = 1'b0;
    logic          last_v = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          last_dbl = 1'b0;

    fpregfile_wb #(.FIFO_DEPTH(DEPTH)) dut (
        .gclk      (gclk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_dbl    (ld_dbl),
        .ld_data   (ld_data),
        .fpu_valid (fpu_valid),
        .fpu_ready (fpu_ready),
        .fpu_addr  (fpu_addr),
        .fpu_dbl   (fpu_dbl),
        .fpu_data  (fpu_data),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .rfc       (rfc)
    );

    initial gclk.clk = 1'b0;
    always #5 gclk.clk = ~gclk.clk;

    function automatic logic [6:0] par(input logic [31:0] w);
`ifdef FPREGFILE_PARITY_EN
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0], 3'b000};
`else
        return 7'd0;
`endif
    endfunction

    function automatic logic [CW-1:0] mk(input logic [AW-1:0] a, input logic dbl, input logic [63:0] d);
        fpregfile_commit_type c;
        c = '0;
        c.ph_addr = a;
        if (dbl) begin
            c.ph1_data = d[31:0];
            c.ph2_data = d[63:32];
            c.ph1_we   = 1'b1;
            c.ph2_we   = 1'b1;
        end else begin
            c.ph1_data = d[31:0];
            c.ph2_data = d[31:0];
            c.ph1_we   = (a[0] == 1'b0);
            c.ph2_we   = (a[0] == 1'b1);
        end
        c.ph1_parity = par(c.ph1_data);
        c.ph2_parity = par(c.ph2_data);
        return c;
    endfunction

    function automatic logic hit_rule(input logic [AW-1:0] a, input logic dbl, input logic [AW-1:0] p);
        if (dbl) return (a >> 1) == (p >> 1);
        return a == p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the model on the edge, then compare DUT outputs 1ns later.
    task automatic tick();
        logic          acc;
        logic          hit_m;
        logic [CW-1:0] e;
        @(posedge gclk.clk);
        if (rst) begin
            mq_addr.delete();
            mq_dbl.delete();
            mq_data.delete();
            ready_m = 1'b0;
            last_v  = 1'b0;
        end else begin
            acc = fpu_valid && ready_m;
            if (ld_valid) begin
                exp_q.push_back(mk(ld_addr, ld_dbl, ld_data));
                last_v = 1'b1; last_addr = ld_addr; last_dbl = ld_dbl;
            end else if (mq_addr.size() != 0) begin
                exp_q.push_back(mk(mq_addr[0], mq_dbl[0], mq_data[0]));
                last_v = 1'b1; last_addr = mq_addr[0]; last_dbl = mq_dbl[0];
                void'(mq_addr.pop_front());
                void'(mq_dbl.pop_front());
                void'(mq_data.pop_front());
            end else begin
                last_v = 1'b0;
            end
            if (acc) begin
                mq_addr.push_back(fpu_addr);
                mq_dbl.push_back(fpu_dbl);
                mq_data.push_back(fpu_data);
            end
            ready_m = (mq_addr.size() != DEPTH);
        end
        #1;
        if (rfc.ph1_we || rfc.ph2_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_commit", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("commit", 128'(rfc), 128'(e));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("missing_commit", 128'(rfc), 128'(e));
        end
        check("fpu_ready", fpu_ready, ready_m);
        hit_m = last_v && hit_rule(last_addr, last_dbl, chk_addr);
        for (int i = 0; i < mq_addr.size(); i++)
            if (hit_rule(mq_addr[i], mq_dbl[i], chk_addr)) hit_m = 1'b1;
        check("chk_hit", chk_hit, hit_m);
    endtask

    initial begin
        rst = 1'b1;
        ld_valid = 0; ld_dbl = 0; ld_addr = '0; ld_data = '0;
        fpu_valid = 0; fpu_dbl = 0; fpu_addr = '0; fpu_data = '0;
        chk_addr = '0;

        // Reset state
        tick();
        tick();
        check("reset_rfc", 128'(rfc), 128'(0));
        check("reset_ready", fpu_ready, 1'b0);
        check("reset_hit", chk_hit, 1'b0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", fpu_ready, 1'b1);

        // Single load to odd word
        ld_valid = 1; ld_addr = 5; ld_dbl = 0; ld_data = 64'h0000_0000_3F80_0000;
        tick();
        ld_valid = 0;
        check("ld_ph_addr", rfc.ph_addr, 5);
        check("ld_ph2_we", rfc.ph2_we, 1'b1);
        check("ld_ph1_we", rfc.ph1_we, 1'b0);
        check("ld_ph2_data", rfc.ph2_data, 32'h3F80_0000);

        // FPU double, two-cycle latency
        fpu_valid = 1; fpu_addr = 6; fpu_dbl = 1; fpu_data = 64'h4009_21FB_5444_2D18;
        tick();
        fpu_valid = 0;
        check("fpu_not_yet", rfc.ph1_we | rfc.ph2_we, 1'b0);
        tick();
        check("fpu_ph1_data", rfc.ph1_data, 32'h5444_2D18);
        check("fpu_ph2_data", rfc.ph2_data, 32'h4009_21FB);
        check("fpu_we", {rfc.ph1_we, rfc.ph2_we}, 2'b11);

        // Fill the FIFO while loads starve it, then drain
        ld_valid = 1; fpu_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = AW'($urandom_range(0, 31)); ld_dbl = 1'($urandom_range(0, 1));
            ld_data = {$urandom, $urandom};
            fpu_addr = AW'(10 + i); fpu_dbl = 1'(i % 2); fpu_data = {$urandom, $urandom};
            chk_addr = AW'(10 + i);
            tick();
        end
        check("full_ready", fpu_ready, 1'b0);
        ld_valid = 0; fpu_valid = 0;
        tick();
        check("ready_after_pop", fpu_ready, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Same-cycle load and FPU push
        ld_valid = 1; ld_addr = 2; ld_dbl = 0; ld_data = 64'h1111_2222;
        fpu_valid = 1; fpu_addr = 9; fpu_dbl = 0; fpu_data = 64'h3333_4444;
        chk_addr = 9;
        tick();
        ld_valid = 0; fpu_valid = 0;
        check("same_cyc_ld_addr", rfc.ph_addr, 2);
        check("same_cyc_hit1", chk_hit, 1'b1);
        tick();
        check("same_cyc_fpu_addr", rfc.ph_addr, 9);
        check("same_cyc_hit2", chk_hit, 1'b1);
        tick();
        check("same_cyc_hit3", chk_hit, 1'b0);

        // Check bits
        ld_valid = 1; ld_addr = 0; ld_dbl = 0; ld_data = 64'h0000_00FF;
        tick();
        check("parity_ff", rfc.ph1_parity, 7'h00);
        ld_data = 64'h0000_0001;
        tick();
        ld_valid = 0;
`ifdef FPREGFILE_PARITY_EN
        check("parity_01", rfc.ph1_parity, 7'h08);
`else
        check("parity_01", rfc.ph1_parity, 7'h00);
`endif

        // Reset with three entries queued
        ld_valid = 1; fpu_valid = 1; chk_addr = 21;
        for (int i = 0; i < 3; i++) begin
            ld_addr = AW'(i); ld_dbl = 0; ld_data = {$urandom, $urandom};
            fpu_addr = AW'(20 + i); fpu_dbl = 0; fpu_data = {$urandom, $urandom};
            tick();
        end
        check("queued_hit", chk_hit, 1'b1);
        ld_valid = 0; fpu_valid = 0; rst = 1;
        tick();
        check("rst_mid_we", rfc.ph1_we | rfc.ph2_we, 1'b0);
        check("rst_mid_hit", chk_hit, 1'b0);
        check("rst_mid_ready", fpu_ready, 1'b0);
        rst = 0;
        for (int i = 0; i < 5; i++) tick();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_addr   = AW'($urandom_range(0, 31));
            ld_dbl    = 1'($urandom_range(0, 1));
            ld_data   = {$urandom, $urandom};
            fpu_valid = 1'($urandom_range(0, 1));
            fpu_addr  = AW'($urandom_range(0, 31));
            fpu_dbl   = 1'($urandom_range(0, 1));
            fpu_data  = {$urandom, $urandom};
            chk_addr  = AW'($urandom_range(0, 31));
            tick();
        end
        ld_valid = 0; fpu_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpregfile_wb.md
# fpregfile_wb

Write-back/commit stage directly upstream of the FP register file. It merges FP load results and FPU results into one register-file write per cycle and generates per-word check bits. It drives the commit bundle (`fpregfile_commit_type`: `ph_addr`, `ph1/ph2_data`, `ph1/ph2_parity`, `ph1/ph2_we`) consumed by the regfile's write port. FPU results are buffered in a small FIFO with back-pressure; loads never stall. A hazard probe lets issue interlock on registers with writes still pending.

## Interface
- `FIFO_DEPTH`, 4, FPU result FIFO entries (power of 2, ≥2)
- `gclk`  in  iu_clk_type  single clock; only `gclk.clk` used, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `ld_valid`  in  1  load result valid; always accepted
- `ld_addr`  in  NFPREGADDRMSB+1  destination register; lsb selects word
- `ld_dbl`  in  1  double-word write (both words)
- `ld_data`  in  64  data; single uses [31:0]
- `fpu_valid`  in  1  FPU result valid
- `fpu_ready`  out  1  FIFO can accept
- `fpu_addr`, `fpu_dbl`, `fpu_data`  in  as load port  FPU result fields
- `chk_addr`  in  NFPREGADDRMSB+1  hazard probe address
- `chk_hit`  out  1  a queued or in-flight write targets `chk_addr`
- `rfc`  out  fpregfile_commit_type  registered commit to regfile

## Operation
- Per cycle, at most one commit selected: a valid load wins; otherwise the FIFO head is popped if non-empty; otherwise no write.
- FPU handshake: transfer on `fpu_valid && fpu_ready`. `fpu_ready` = FIFO not full, registered, from state only. It does not look ahead to a same-cycle pop.
- Push and pop in the same cycle are legal when not full. Count is unchanged; pointers wrap modulo `FIFO_DEPTH`.
- Commit formatting:
  - `ph_addr` = selected address.
  - Double: `ph1_data`=data[31:0], `ph2_data`=data[63:32], both `we`=1. Address lsb is ignored.
  - Single, lsb=0: `ph1_we`=1, `ph2_we`=0.
  - Single, lsb=1: `ph1_we`=0, `ph2_we`=1.
  - For singles, data[31:0] is driven on both `ph1_data` and `ph2_data`.
- Check-bit generation for both words follows Configuration.
- Hazard match rule:
  - Singles match on the full address.
  - Doubles match on the address with the lsb ignored.
  - `chk_hit` is combinational over valid FIFO entries plus the registered `rfc` stage.
- Ordering: a load and an FPU result to the same register in the same cycle both commit, load first. Issue uses `chk_hit` to prevent this.

## Timing
- Latency:
  - Load: `rfc` valid the cycle after `ld_valid`.
  - FPU result into empty FIFO with no load present: `rfc` valid 2 cycles after the handshake (FIFO write, then pop into the `rfc` register).
- A load stalls FIFO draining for exactly that cycle. Continuous loads starve the FIFO; no fairness is guaranteed.
- Reset (synchronous, takes effect on the clock edge):
  - FIFO empty.
  - `fpu_ready`=0 during reset, 1 on the first cycle after.
  - `rfc` all fields 0 (`we`=0).
  - `chk_hit`=0.
- Reset mid-operation: all queued writes are dropped; no partial commit.
- FIFO full: `fpu_ready`=0. It returns to 1 the cycle after a pop with no push.

## Configuration
- Macro `FPREGFILE_PARITY_EN`.
- Defined: for each word w, `parity[3+k]` = XOR of bits w[8k+7:8k], k=0..3, and `parity[2:0]`=0. Only bits [6:3] are stored downstream.
- Undefined: all parity outputs are 0 and no XOR logic is built.

## Test plan
- Reset, then single load addr=5, data=0x3F800000 -> next cycle `ph_addr`=5, `ph2_we`=1, `ph1_we`=0, `ph2_data`=0x3F800000.
- FPU double addr=6, data=0x400921FB54442D18, no loads -> 2 cycles later both `we`=1, `ph1_data`=0x54442D18, `ph2_data`=0x400921FB.
- Push 4 FPU results with `ld_valid` held high -> `fpu_ready`=0 after the 4th. Drop `ld_valid` -> 4 commits in order; `fpu_ready`=1 the cycle after the first pop.
- Same-cycle load and FPU push, FIFO empty -> load commits at cycle 1, FPU result at cycle 2; `chk_hit` asserts for the FPU address during cycles 1–2.
- With `FPREGFILE_PARITY_EN`, single data=0x000000FF -> `parity`=0x00. Data=0x00000001 -> `parity[3]`=1. Without the macro -> `parity`=0 in both cases.
- `rst` asserted with 3 entries queued -> next cycle `rfc.we`=0, `chk_hit`=0, FIFO empty. After reset, no stale commit appears.
